// File: rtl/voice_mixer.sv
// voice_mixer
//   Collects one signed sample per voice each audio frame, pans every voice
//   into left/right with a 0..8 pan weight, sums the voices, applies an
//   unsigned master volume followed by an arithmetic right shift, and
//   saturates the result to signed 24 bits for the DAC.
//
// Ports
//   clk           hardware clock
//   rst_mix_n     asynchronous active-low reset
//   sample_req    1-cycle pulse, start collecting a frame (only honoured in IDLE)
//   voice_valid   voice sample offered
//   voice_ready   mixer accepts a voice sample this cycle (COLLECT)
//   voice_sample  signed sample of voice voice_idx
//   voice_idx     index of the voice expected next
//   msg_en/msg_addr/msg   configuration bus (volume and per-voice pan)
//   left/right    signed 24-bit mix, held between frames
//   out_valid     1-cycle pulse when left/right update
//   busy          frame in progress
//   overrun       sticky, sample_req seen while busy

// Per-voice pan register; reset to centre (4).
module voice_pan_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] din,
  output logic [3:0] pan
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  pan <= 4'd4;
    else if (we) pan <= din;
  end
endmodule

module voice_mixer #(
  parameter int          VOICES    = 8,
  parameter int          IN_W      = 16,
  parameter int          VOL_SHIFT = 2,
  parameter logic [31:0] MSG_ADDR  = 32'hFFFF_FFFE
) (
  input  logic            clk,
  input  logic            rst_mix_n,
  input  logic            sample_req,
  input  logic            voice_valid,
  output logic            voice_ready,
  input  logic [IN_W-1:0] voice_sample,
  output logic [3:0]      voice_idx,
  input  logic            msg_en,
  input  logic [31:0]     msg_addr,
  input  logic [31:0]     msg,
  output logic [23:0]     left,
  output logic [23:0]     right,
  output logic            out_valid,
  output logic            busy,
  output logic            overrun
);

  // Sample * pan (0..8) needs IN_W+4 bits; summing VOICES terms adds clog2.
  localparam int ACC_W  = IN_W + 4 + $clog2(VOICES);
  // Accumulator times a zero-extended 8-bit volume (signed 9 bits).
  localparam int P_W    = ACC_W + 9;
  localparam int TERM_W = IN_W + 5;

  localparam logic signed [P_W-1:0] SAT_MAX = P_W'(32'sd8388607);
  localparam logic signed [P_W-1:0] SAT_MIN = P_W'(-32'sd8388608);

  typedef enum logic [1:0] {IDLE, COLLECT, SCALE, OUT} state_t;
  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Configuration
  // ---------------------------------------------------------------------
  logic                    msg_hit;
  logic [3:0]              pan_din;
  logic [7:0]              vol;
  logic [VOICES-1:0]       pan_we;
  logic [VOICES-1:0][3:0]  pan;

  assign msg_hit = msg_en && (msg_addr == MSG_ADDR);
  assign pan_din = (msg[3:0] > 4'd8) ? 4'd8 : msg[3:0];

  always_ff @(posedge clk or negedge rst_mix_n) begin
    if (!rst_mix_n)            vol <= 8'd128;
    else if (msg_hit && msg[31]) vol <= msg[7:0];
  end

  // Out-of-range pan indices match no lane and are dropped naturally.
  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_pan
      assign pan_we[gi] = msg_hit && !msg[31] && (msg[11:8] == 4'(gi));
      voice_pan_reg u_pan (
        .clk  (clk),
        .rst_n(rst_mix_n),
        .we   (pan_we[gi]),
        .din  (pan_din),
        .pan  (pan[gi])
      );
    end
  endgenerate

  // Pan of the voice being offered. A same-edge pan write lands after this
  // edge, so the acceptance sees the old value.
  logic [3:0] cur_pan;
  always_comb begin
    cur_pan = 4'd0;
    for (int i = 0; i < VOICES; i++)
      if (voice_idx == 4'(i)) cur_pan = pan[i];
  end

  // ---------------------------------------------------------------------
  // Per-voice weighting
  // ---------------------------------------------------------------------
  logic [3:0]               wl;
  logic signed [TERM_W-1:0] samp_x, wl_x, wr_x, term_l, term_r;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic                     accept, last_voice;

  assign wl     = 4'd8 - cur_pan;
  assign samp_x = TERM_W'($signed(voice_sample));
  assign wl_x   = $signed(TERM_W'(wl));
  assign wr_x   = $signed(TERM_W'(cur_pan));
  assign term_l = samp_x * wl_x;
  assign term_r = samp_x * wr_x;

  assign accept     = voice_valid && voice_ready;
  assign last_voice = (voice_idx == 4'(VOICES - 1));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_mix_n) begin
    if (!rst_mix_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_req) state_nxt = COLLECT;
      COLLECT: if (accept && last_voice) state_nxt = SCALE;
      SCALE:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign voice_ready = (state == COLLECT);
  assign busy        = (state != IDLE);

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic signed [P_W-1:0] p_l, p_r, vol_x, sh_l, sh_r;

  assign vol_x = $signed(P_W'(vol));
  assign sh_l  = p_l >>> VOL_SHIFT;
  assign sh_r  = p_r >>> VOL_SHIFT;

  function automatic logic [23:0] sat24(input logic signed [P_W-1:0] v);
    if (v > SAT_MAX)      return 24'h7F_FFFF;
    else if (v < SAT_MIN) return 24'h80_0000;
    else                  return v[23:0];
  endfunction

  always_ff @(posedge clk or negedge rst_mix_n) begin
    if (!rst_mix_n) begin
      acc_l     <= '0;
      acc_r     <= '0;
      voice_idx <= 4'd0;
      p_l       <= '0;
      p_r       <= '0;
      left      <= 24'd0;
      right     <= 24'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      if (sample_req && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: if (sample_req) begin
          acc_l     <= '0;
          acc_r     <= '0;
          voice_idx <= 4'd0;
        end
        COLLECT: if (accept) begin
          acc_l     <= acc_l + ACC_W'(term_l);
          acc_r     <= acc_r + ACC_W'(term_r);
          voice_idx <= last_voice ? 4'd0 : voice_idx + 4'd1;
        end
        SCALE: begin
          p_l <= P_W'(acc_l) * vol_x;
          p_r <= P_W'(acc_r) * vol_x;
        end
        OUT: begin
          left  <= sat24(sh_l);
          right <= sat24(sh_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

  logic        clk = 1'b0;
  logic        rst_mix_n;
  logic        sample_req;
  logic        voice_valid;
  logic        voice_ready;
  logic [15:0] voice_sample;
  logic [3:0]  voice_idx;
  logic        msg_en;
  logic [31:0] msg_addr;
  logic [31:0] msg;
  logic [23:0] left, right;
  logic        out_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDR = 32'hFFFF_FFFE;

  typedef logic signed [15:0] vec_t [8];

  always #5 clk = ~clk;

  voice_mixer dut (
    .clk         (clk),
    .rst_mix_n   (rst_mix_n),
    .sample_req  (sample_req),
    .voice_valid (voice_valid),
    .voice_ready (voice_ready),
    .voice_sample(voice_sample),
    .voice_idx   (voice_idx),
    .msg_en      (msg_en),
    .msg_addr    (msg_addr),
    .msg         (msg),
    .left        (left),
    .right       (right),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic apply_reset();
    rst_mix_n = 1'b0; sample_req = 0; voice_valid = 0; voice_sample = 0;
    msg_en = 0; msg_addr = 0; msg = 0;
    repeat (3) @(negedge clk);
    rst_mix_n = 1'b1;
  endtask

  task automatic msg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); msg_en = 1; msg_addr = a; msg = d;
    @(negedge clk); msg_en = 0;
  endtask

  // Runs one frame. ovr[0] pulses sample_req during COLLECT, ovr[1] during OUT.
  // lat = edges from last accept to out_valid; nvalid = out_valid pulses seen.
  task automatic do_frame(input vec_t s, input bit gaps, input logic [1:0] ovr,
                          output logic signed [23:0] l, output logic signed [23:0] r,
                          output int nvalid, output int lat, output bit idx_ok);
    int n = 0, cyc = 0;
    bit acc;
    idx_ok = 1; nvalid = 0;
    @(negedge clk); sample_req = 1;
    @(negedge clk); sample_req = 0;
    while (n < 8 && cyc < 200) begin
      voice_valid  = gaps ? (cyc % 3 == 0) : 1'b1;
      voice_sample = s[n];
      sample_req   = ovr[0] && (cyc == 2);
      if (voice_idx !== 4'(n)) idx_ok = 0;
      acc = voice_valid && voice_ready;
      @(negedge clk);
      if (acc) n++;
      cyc++;
    end
    voice_valid = 0; sample_req = 0; lat = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
      sample_req = ovr[1] && (lat == 1);
    end
    sample_req = 0;
    l = left; r = right;
    if (out_valid === 1'b1) nvalid = 1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
    end
  endtask

  task automatic test_reset();
    vec_t v = '{16'sd1000, 0, 0, 0, 0, 0, 0, 0};
    logic signed [23:0] l, r;
    int nv, lat; bit ok;
    apply_reset();
    checks++; if (left !== 24'd0)    begin failures++; $display("FAIL reset_left got %0d want 0", left); end
    checks++; if (right !== 24'd0)   begin failures++; $display("FAIL reset_right got %0d want 0", right); end
    checks++; if (out_valid !== 0)   begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (voice_ready !== 0) begin failures++; $display("FAIL reset_ready got %b want 0", voice_ready); end
    checks++; if (voice_idx !== 0)   begin failures++; $display("FAIL reset_idx got %0d want 0", voice_idx); end
    checks++; if (busy !== 0)        begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 0)     begin failures++; $display("FAIL reset_overrun got %b want 0", overrun); end
    do_frame(v, 0, 2'b00, l, r, nv, lat, ok);
    checks++; if (l !== 24'sd128000) begin failures++; $display("FAIL default_left got %0d want 128000", l); end
    checks++; if (r !== 24'sd128000) begin failures++; $display("FAIL default_right got %0d want 128000", r); end
    checks++; if (nv !== 1)          begin failures++; $display("FAIL default_pulses got %0d want 1", nv); end
    checks++; if (lat !== 2)         begin failures++; $display("FAIL default_latency got %0d want 2", lat); end
    checks++; if (!ok)               begin failures++; $display("FAIL default_idx_seq got 0 want 1"); end
  endtask

  task automatic test_pan_clamp();
    vec_t v = '{16'sd100, -16'sd50, 0, 0, 0, 0, 0, 0};
    logic signed [23:0] l, r, el, er;
    int nv, lat; bit ok;
    msg_write(32'hFFFF_FFFD, 32'h8000_0000);  // foreign address: vol must stay
    msg_write(ADDR, 32'h0000_0000);           // pan0 = 0
    msg_write(ADDR, 32'h0000_010F);           // pan1 = 15 -> 8
    msg_write(ADDR, 32'h0000_0808);           // index 8 out of range, dropped
    msg_write(ADDR, 32'h8000_0004);           // vol = 4
    do_frame(v, 0, 2'b00, l, r, nv, lat, ok);
    el = 800; er = -400;
    checks++; if (l !== el) begin failures++; $display("FAIL pan_left got %0d want %0d", l, el); end
    checks++; if (r !== er) begin failures++; $display("FAIL pan_right got %0d want %0d", r, er); end
    msg_write(ADDR, 32'h0000_0004);
    msg_write(ADDR, 32'h0000_0104);
  endtask

  task automatic test_saturation();
    vec_t vp = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767,
                 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
    vec_t vn = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
                 -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    vec_t v1 = '{-16'sd1, 0, 0, 0, 0, 0, 0, 0};
    logic signed [23:0] l, r, e;
    int nv, lat; bit ok;
    msg_write(ADDR, 32'h8000_00FF);
    do_frame(vp, 0, 2'b00, l, r, nv, lat, ok);
    e = 24'sh7F_FFFF;
    checks++; if (l !== e) begin failures++; $display("FAIL sat_pos_left got %0d want %0d", l, e); end
    checks++; if (r !== e) begin failures++; $display("FAIL sat_pos_right got %0d want %0d", r, e); end
    do_frame(vn, 0, 2'b00, l, r, nv, lat, ok);
    e = 24'sh80_0000;
    checks++; if (l !== e) begin failures++; $display("FAIL sat_neg_left got %0d want %0d", l, e); end
    checks++; if (r !== e) begin failures++; $display("FAIL sat_neg_right got %0d want %0d", r, e); end
    msg_write(ADDR, 32'h8000_0001);
    do_frame(v1, 0, 2'b00, l, r, nv, lat, ok);
    e = -1;
    checks++; if (l !== e) begin failures++; $display("FAIL floor_left got %0d want %0d", l, e); end
    checks++; if (r !== e) begin failures++; $display("FAIL floor_right got %0d want %0d", r, e); end
  endtask

  task automatic test_gaps();
    vec_t v = '{16'sd1000, -16'sd2000, 16'sd300, 0, 0, 0, 0, 16'sd500};
    logic signed [23:0] l, r, e;
    int nv, lat; bit ok;
    msg_write(ADDR, 32'h8000_0080);
    // voice_valid while IDLE must not start anything
    @(negedge clk); voice_valid = 1; voice_sample = 16'd1234;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 0 || voice_ready !== 0 || voice_idx !== 0 || out_valid !== 0) begin
      failures++; $display("FAIL idle_valid got busy=%b ready=%b idx=%0d ov=%b want 0 0 0 0",
                           busy, voice_ready, voice_idx, out_valid);
    end
    voice_valid = 0;
    e = -25600;
    do_frame(v, 0, 2'b00, l, r, nv, lat, ok);
    checks++; if (l !== e || r !== e) begin failures++; $display("FAIL gapless got %0d/%0d want %0d", l, r, e); end
    do_frame(v, 1, 2'b00, l, r, nv, lat, ok);
    checks++; if (l !== e) begin failures++; $display("FAIL gap_left got %0d want %0d", l, e); end
    checks++; if (r !== e) begin failures++; $display("FAIL gap_right got %0d want %0d", r, e); end
    checks++; if (!ok)     begin failures++; $display("FAIL gap_idx_seq got 0 want 1"); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL gap_pulses got %0d want 1", nv); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL gap_latency got %0d want 2", lat); end
  endtask

  task automatic test_overrun();
    vec_t v = '{16'sd1000, 0, 0, 0, 0, 0, 0, 0};
    logic signed [23:0] l, r;
    int nv, lat; bit ok;
    apply_reset();
    do_frame(v, 0, 2'b10, l, r, nv, lat, ok);   // sample_req during OUT only
    checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_out got %b want 1", overrun); end
    checks++; if (busy !== 0)    begin failures++; $display("FAIL ovr_out_busy got %b want 0", busy); end
    checks++; if (l !== 24'sd128000 || nv !== 1) begin
      failures++; $display("FAIL ovr_out_frame got %0d pulses=%0d want 128000 pulses=1", l, nv);
    end
    apply_reset();
    do_frame(v, 0, 2'b01, l, r, nv, lat, ok);   // sample_req during COLLECT
    checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_collect got %b want 1", overrun); end
    checks++; if (l !== 24'sd128000 || r !== 24'sd128000) begin
      failures++; $display("FAIL ovr_collect_frame got %0d/%0d want 128000", l, r);
    end
    checks++; if (nv !== 1 || busy !== 0) begin
      failures++; $display("FAIL ovr_no_extra got pulses=%0d busy=%b want 1 0", nv, busy);
    end
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_async_reset();
    vec_t v = '{16'sd1000, 0, 0, 0, 0, 0, 0, 0};
    logic signed [23:0] l, r;
    int nv, lat, pulses = 0; bit ok;
    @(negedge clk); sample_req = 1;
    @(negedge clk); sample_req = 0; voice_valid = 1; voice_sample = 16'd1000;
    repeat (3) @(negedge clk);
    voice_valid = 0;
    #2 rst_mix_n = 0;
    #1;
    checks++; if (left !== 0 || right !== 0) begin
      failures++; $display("FAIL async_lr got %0d/%0d want 0/0", left, right);
    end
    checks++; if (busy !== 0 || voice_ready !== 0 || voice_idx !== 0 || overrun !== 0) begin
      failures++; $display("FAIL async_ctl got busy=%b ready=%b idx=%0d ovr=%b want 0 0 0 0",
                           busy, voice_ready, voice_idx, overrun);
    end
    @(negedge clk); rst_mix_n = 1;
    repeat (5) begin @(negedge clk); if (out_valid === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL async_partial got %0d pulses want 0", pulses); end
    do_frame(v, 0, 2'b00, l, r, nv, lat, ok);
    checks++; if (l !== 24'sd128000 || r !== 24'sd128000) begin
      failures++; $display("FAIL async_fresh got %0d/%0d want 128000", l, r);
    end
  endtask

  initial begin
    test_reset();
    test_pan_clamp();
    test_saturation();
    test_gaps();
    test_overrun();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
